reg_bank_sb: RTL and testbench
==============================

REG_BANK_SB -- requirements
Module: reg_bank_sb

Interface
REQ-001 Parameter ADDR_W, default 5: register address width.
REQ-002 Parameter DATA_W, default 32: register data width.
REQ-003 Parameter NUM_REGS, default 1<<ADDR_W: number of architectural registers, which SHALL be at most 1<<ADDR_W.
REQ-004 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 RegWEn  input  1  write enable for the write-back port.
REQ-007 AddrD  input  ADDR_W  write-back destination address.
REQ-008 DataD  input  DATA_W  write-back data.
REQ-009 IssueEn  input  1  marks IssueAddr busy, meaning a pending write exists.
REQ-010 IssueAddr  input  ADDR_W  destination register of the issuing instruction.
REQ-011 AddrA / AddrB  input  ADDR_W  read addresses for ports A and B.
REQ-012 DataA / DataB  output  DATA_W  read data for ports A and B.
REQ-013 BusyA / BusyB  output  1  asserted when the addressed register has a pending write.

Function
REQ-014 Reads SHALL be combinational: DataX = REG[AddrX] and BusyX = busy[AddrX], with zero-cycle latency.
REQ-015 When RegWEn=1 and AddrD!=0, REG[AddrD] SHALL load DataD on the rising clk edge.
REQ-016 Register 0 SHALL always read 0 with Busy=0; writes and issues to address 0 SHALL be ignored.
REQ-017 When IssueEn=1 and IssueAddr!=0, busy[IssueAddr] SHALL be set on the rising edge.
REQ-018 When RegWEn=1 and AddrD!=0, busy[AddrD] SHALL be cleared on the rising edge.
REQ-019 If an issue and a write target the same address in the same cycle, busy SHALL end set, because the new issue wins.
REQ-020 A write to a register that is not busy SHALL still update data, and busy SHALL stay 0.
REQ-021 Issuing to a register that is already busy SHALL leave it busy, with no error and no counting.
REQ-022 A read address >= NUM_REGS SHALL return DataX=0 and BusyX=0.
REQ-023 Ports A and B SHALL be fully independent, and AddrA==AddrB SHALL return identical values.

Reset
REQ-024 While rst=1, all REG entries and all busy bits SHALL be 0 immediately, without waiting for a clock edge.
REQ-025 During reset, DataA, DataB, BusyA and BusyB SHALL read 0, and writes and issues SHALL be ignored.
REQ-026 On rst deassertion the first active edge SHALL behave as normal operation, and state pending at reset SHALL be lost.

Configuration
REQ-027 With REG_BANK_BYPASS_EN defined: if RegWEn=1, AddrD!=0 and AddrD==AddrX, then DataX SHALL equal DataD and BusyX SHALL be 0 in the same cycle.
REQ-028 Without REG_BANK_BYPASS_EN: reads SHALL show only stored state, so a write is visible on the cycle after its edge and Busy stays asserted until then.
REQ-029 Bypass SHALL NOT override register 0 and SHALL NOT affect stored state.

Structure
REQ-030 Package reg_bank_pkg SHALL hold the ADDR_W and DATA_W defaults, a ZERO_REG address constant and the reg_addr_t/reg_data_t typedefs.
REQ-031 Busy-bit logic SHALL be a sub-module reg_bank_scoreboard (set/clear vector plus two read ports), instantiated once.
REQ-032 Data storage and the read/bypass mux SHALL be in the top level; no other sub-modules.

Verification
REQ-033 Reset: assert rst mid-run after writing 0xDEADBEEF to x5 -> DataA(x5)=0 and BusyA=0 at once, without a clock.
REQ-034 Write/read: write 0x12345678 to x7, then AddrA=7 next cycle -> DataA=0x12345678, BusyA=0; write 0xFFFFFFFF to x0 -> DataA(x0)=0.
REQ-035 Scoreboard: issue x3, then read x3 -> BusyB=1; write x3=0xA5 -> BusyB=0 next cycle, DataB=0xA5.
REQ-036 Collision: issue x9 and write x9=0x55 in the same cycle -> next cycle BusyA(x9)=1, DataA=0x55.
REQ-037 Bypass: x4 busy, same-cycle write x4=0x77 with AddrA=4 -> with the macro, DataA=0x77 and BusyA=0 combinationally; without it, the old value and BusyA=1 until the edge.
REQ-038 Out-of-range: NUM_REGS=16, AddrB=20 -> DataB=0, BusyB=0.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared widths, address constants and types for the register bank.
package reg_bank_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;

    // x0 is hardwired to zero and never marked busy
    localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/reg_bank_scoreboard.sv
// Busy-bit scoreboard: one pending-write flag per register, set on issue,
// cleared on write-back, with two combinational read ports.
module reg_bank_scoreboard
    import reg_bank_pkg::*;
#(
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int NUM_REGS = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    output logic              busy_a,
    output logic              busy_b
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Next busy vector: clear applied first so a same-cycle issue wins; x0 stays clear
    always_comb begin
        busy_d    = busy_q;
        busy_d[0] = 1'b0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (clr_en && clr_addr == ADDR_W'(i)) busy_d[i] = 1'b0;
            if (set_en && set_addr == ADDR_W'(i)) busy_d[i] = 1'b1;
        end
    end

    // Busy storage, wiped immediately by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    // Read ports: x0 and out-of-range addresses never match, so they read 0
    always_comb begin
        busy_a = 1'b0;
        busy_b = 1'b0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (addr_a == ADDR_W'(i)) busy_a = busy_q[i];
            if (addr_b == ADDR_W'(i)) busy_b = busy_q[i];
        end
    end

endmodule

// File: rtl/reg_bank_sb.sv
// Two-read, one-write register bank with a busy scoreboard.
// Optional macro REG_BANK_BYPASS_EN forwards a same-cycle write-back to the
// read ports (data shown, busy hidden) without touching stored state.
module reg_bank_sb
    import reg_bank_pkg::*;
#(
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int DATA_W   = REG_DATA_W,
    parameter int NUM_REGS = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWEn,
    input  logic [ADDR_W-1:0] AddrD,
    input  logic [DATA_W-1:0] DataD,
    input  logic              IssueEn,
    input  logic [ADDR_W-1:0] IssueAddr,
    input  logic [ADDR_W-1:0] AddrA,
    input  logic [ADDR_W-1:0] AddrB,
    output logic [DATA_W-1:0] DataA,
    output logic [DATA_W-1:0] DataB,
    output logic              BusyA,
    output logic              BusyB
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] stored_a;
    logic [DATA_W-1:0] stored_b;
    logic              sb_busy_a;
    logic              sb_busy_b;
    logic              wr_valid;

    assign wr_valid = RegWEn && (AddrD != ADDR_W'(ZERO_REG));

    reg_bank_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (IssueEn),
        .set_addr (IssueAddr),
        .clr_en   (RegWEn),
        .clr_addr (AddrD),
        .addr_a   (AddrA),
        .addr_b   (AddrB),
        .busy_a   (sb_busy_a),
        .busy_b   (sb_busy_b)
    );

    // Register storage: x0 is never written, out-of-range writes match nothing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (wr_valid && AddrD == ADDR_W'(i)) regs[i] <= DataD;
            end
        end
    end

    // Stored-state read mux; x0 and out-of-range addresses read 0
    always_comb begin
        stored_a = '0;
        stored_b = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (AddrA == ADDR_W'(i)) stored_a = regs[i];
            if (AddrB == ADDR_W'(i)) stored_b = regs[i];
        end
    end

`ifdef REG_BANK_BYPASS_EN
    logic wr_hit;
    logic byp_a;
    logic byp_b;

    // A write-back only forwards when it would actually land in a real register
    always_comb begin
        wr_hit = 1'b0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (AddrD == ADDR_W'(i)) wr_hit = wr_valid;
        end
    end

    assign byp_a = wr_hit && !rst && (AddrD == AddrA);
    assign byp_b = wr_hit && !rst && (AddrD == AddrB);

    assign DataA = byp_a ? DataD : stored_a;
    assign DataB = byp_b ? DataD : stored_b;
    assign BusyA = byp_a ? 1'b0  : sb_busy_a;
    assign BusyB = byp_b ? 1'b0  : sb_busy_b;
`else
    assign DataA = stored_a;
    assign DataB = stored_b;
    assign BusyA = sb_busy_a;
    assign BusyB = sb_busy_b;
`endif

endmodule

// File: tb/tb_reg_bank_sb.sv
// Self-checking bench for reg_bank_sb (NUM_REGS=16 so out-of-range reads
// are reachable). Expectations follow REG_BANK_BYPASS_EN when defined.
module tb_reg_bank_sb;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int NREGS = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          RegWEn = 1'b0;
    logic [AW-1:0] AddrD = '0;
    logic [DW-1:0] DataD = '0;
    logic          IssueEn = 1'b0;
    logic [AW-1:0] IssueAddr = '0;
    logic [AW-1:0] AddrA = '0;
    logic [AW-1:0] AddrB = '0;
    logic [DW-1:0] DataA;
    logic [DW-1:0] DataB;
    logic          BusyA;
    logic          BusyB;

    int total = 0;
    int bad   = 0;

    // Reference model: architectural contents and pending-write flags
    logic [DW-1:0] m_data [NREGS];
    logic          m_busy [NREGS];

    reg_bank_sb #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .NUM_REGS (NREGS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .RegWEn    (RegWEn),
        .AddrD     (AddrD),
        .DataD     (DataD),
        .IssueEn   (IssueEn),
        .IssueAddr (IssueAddr),
        .AddrA     (AddrA),
        .AddrB     (AddrB),
        .DataA     (DataA),
        .DataB     (DataB),
        .BusyA     (BusyA),
        .BusyB     (BusyB)
    );

    always #5 clk = ~clk;

    function automatic void model_clear();
        for (int i = 0; i < NREGS; i++) begin
            m_data[i] = '0;
            m_busy[i] = 1'b0;
        end
    endfunction

    function automatic logic [DW-1:0] exp_data(input int addr);
        if (rst || addr == 0 || addr >= NREGS) return '0;
`ifdef REG_BANK_BYPASS_EN
        if (RegWEn && int'(AddrD) == addr) return DataD;
`endif
        return m_data[addr];
    endfunction

    function automatic logic exp_busy(input int addr);
        if (rst || addr == 0 || addr >= NREGS) return 1'b0;
`ifdef REG_BANK_BYPASS_EN
        if (RegWEn && int'(AddrD) == addr) return 1'b0;
`endif
        return m_busy[addr];
    endfunction

    task automatic idle();
        RegWEn    = 1'b0;
        AddrD     = '0;
        DataD     = '0;
        IssueEn   = 1'b0;
        IssueAddr = '0;
    endtask

    // Apply the architectural effect of the current inputs, then clock once
    task automatic tick();
        int d;
        int ia;
        d  = int'(AddrD);
        ia = int'(IssueAddr);
        if (!rst) begin
            if (RegWEn && d != 0 && d < NREGS) begin
                m_data[d] = DataD;
                m_busy[d] = 1'b0;
            end
            if (IssueEn && ia != 0 && ia < NREGS) m_busy[ia] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        model_clear();
        AddrA = 5;
        AddrB = 6;
        #2;
        total++;
        if (DataA !== 32'h0 || BusyA !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_initial: DataA=%h BusyA=%b, want 0/0", DataA, BusyA);
        end
        // writes and issues while reset is held are ignored
        RegWEn = 1'b1; AddrD = 5; DataD = 32'hCAFE0001;
        IssueEn = 1'b1; IssueAddr = 6;
        tick();
        total++;
        if (DataA !== 32'h0 || BusyB !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_ignores_write: DataA=%h BusyB=%b, want 0/0", DataA, BusyB);
        end
        rst = 1'b0;
        DataD = 32'hDEADBEEF;
        tick();
        idle();
        #1;
        total++;
        if (DataA !== 32'hDEADBEEF || BusyB !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_prewrite: DataA=%h BusyB=%b, want deadbeef/1", DataA, BusyB);
        end
        // async reset mid-cycle, no clock edge in between
        rst = 1'b1;
        #1;
        model_clear();
        total++;
        if (DataA !== 32'h0 || BusyA !== 1'b0 || BusyB !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_async: DataA=%h BusyA=%b BusyB=%b, want 0/0/0", DataA, BusyA, BusyB);
        end
        tick();
        rst = 1'b0;
        tick();
        total++;
        if (DataA !== 32'h0 || BusyB !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_state_lost: DataA=%h BusyB=%b, want 0/0", DataA, BusyB);
        end
    endtask

    task automatic test_write_read();
        RegWEn = 1'b1; AddrD = 7; DataD = 32'h12345678;
        tick();
        idle();
        AddrA = 7;
        #1;
        total++;
        if (DataA !== 32'h12345678 || BusyA !== 1'b0) begin
            bad++;
            $display("[TB] FAIL write_read_x7: DataA=%h BusyA=%b, want 12345678/0", DataA, BusyA);
        end
        RegWEn = 1'b1; AddrD = 0; DataD = 32'hFFFFFFFF;
        IssueEn = 1'b1; IssueAddr = 0;
        tick();
        idle();
        AddrA = 0;
        #1;
        total++;
        if (DataA !== 32'h0 || BusyA !== 1'b0) begin
            bad++;
            $display("[TB] FAIL write_x0: DataA=%h BusyA=%b, want 0/0", DataA, BusyA);
        end
    endtask

    task automatic test_scoreboard();
        IssueEn = 1'b1; IssueAddr = 3;
        tick();
        idle();
        AddrB = 3;
        #1;
        total++;
        if (BusyB !== 1'b1) begin
            bad++;
            $display("[TB] FAIL sb_issue: BusyB=%b, want 1", BusyB);
        end
        // re-issue while already busy leaves it busy
        IssueEn = 1'b1; IssueAddr = 3;
        tick();
        idle();
        #1;
        total++;
        if (BusyB !== 1'b1) begin
            bad++;
            $display("[TB] FAIL sb_reissue: BusyB=%b, want 1", BusyB);
        end
        RegWEn = 1'b1; AddrD = 3; DataD = 32'hA5;
        tick();
        idle();
        #1;
        total++;
        if (BusyB !== 1'b0 || DataB !== 32'hA5) begin
            bad++;
            $display("[TB] FAIL sb_clear: DataB=%h BusyB=%b, want a5/0", DataB, BusyB);
        end
    endtask

    task automatic test_collision();
        IssueEn = 1'b1; IssueAddr = 9;
        RegWEn = 1'b1; AddrD = 9; DataD = 32'h55;
        tick();
        idle();
        AddrA = 9;
        #1;
        total++;
        if (BusyA !== 1'b1 || DataA !== 32'h55) begin
            bad++;
            $display("[TB] FAIL collision: DataA=%h BusyA=%b, want 55/1", DataA, BusyA);
        end
    endtask

    task automatic test_bypass();
        logic [DW-1:0] want_d;
        logic          want_b;
        RegWEn = 1'b1; AddrD = 4; DataD = 32'h11;
        tick();
        idle();
        IssueEn = 1'b1; IssueAddr = 4;
        tick();
        idle();
        RegWEn = 1'b1; AddrD = 4; DataD = 32'h77;
        AddrA = 4;
        #1;
`ifdef REG_BANK_BYPASS_EN
        want_d = 32'h77; want_b = 1'b0;
`else
        want_d = 32'h11; want_b = 1'b1;
`endif
        total++;
        if (DataA !== want_d || BusyA !== want_b) begin
            bad++;
            $display("[TB] FAIL bypass_same_cycle: DataA=%h BusyA=%b, want %h/%b", DataA, BusyA, want_d, want_b);
        end
        tick();
        idle();
        #1;
        total++;
        if (DataA !== 32'h77 || BusyA !== 1'b0) begin
            bad++;
            $display("[TB] FAIL bypass_after_edge: DataA=%h BusyA=%b, want 77/0", DataA, BusyA);
        end
        // write to x0 never forwards
        RegWEn = 1'b1; AddrD = 0; DataD = 32'h99;
        AddrB = 0;
        #1;
        total++;
        if (DataB !== 32'h0 || BusyB !== 1'b0) begin
            bad++;
            $display("[TB] FAIL bypass_x0: DataB=%h BusyB=%b, want 0/0", DataB, BusyB);
        end
        idle();
    endtask

    task automatic test_out_of_range();
        RegWEn = 1'b1; AddrD = 20; DataD = 32'h1234;
        IssueEn = 1'b1; IssueAddr = 20;
        AddrB = 20;
        #1;
        total++;
        if (DataB !== 32'h0 || BusyB !== 1'b0) begin
            bad++;
            $display("[TB] FAIL oor_same_cycle: DataB=%h BusyB=%b, want 0/0", DataB, BusyB);
        end
        tick();
        idle();
        #1;
        total++;
        if (DataB !== 32'h0 || BusyB !== 1'b0) begin
            bad++;
            $display("[TB] FAIL oor_read: DataB=%h BusyB=%b, want 0/0", DataB, BusyB);
        end
        AddrA = 7;
        AddrB = 7;
        #1;
        total++;
        if (DataA !== DataB || BusyA !== BusyB || DataA !== m_data[7]) begin
            bad++;
            $display("[TB] FAIL same_addr: A=%h/%b B=%h/%b, want %h", DataA, BusyA, DataB, BusyB, m_data[7]);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            RegWEn    = 1'($urandom_range(0, 1));
            AddrD     = AW'($urandom_range(0, NREGS + 3));
            DataD     = $urandom;
            IssueEn   = 1'($urandom_range(0, 1));
            IssueAddr = AW'($urandom_range(0, NREGS + 3));
            AddrA     = AW'($urandom_range(0, NREGS + 3));
            AddrB     = ($urandom_range(0, 3) == 0) ? AddrD : AW'($urandom_range(0, NREGS + 3));
            #1;
            total++;
            if (DataA !== exp_data(int'(AddrA)) || BusyA !== exp_busy(int'(AddrA))) begin
                bad++;
                $display("[TB] FAIL rand_portA n=%0d addr=%0d: got %h/%b want %h/%b", n, AddrA,
                         DataA, BusyA, exp_data(int'(AddrA)), exp_busy(int'(AddrA)));
            end
            total++;
            if (DataB !== exp_data(int'(AddrB)) || BusyB !== exp_busy(int'(AddrB))) begin
                bad++;
                $display("[TB] FAIL rand_portB n=%0d addr=%0d: got %h/%b want %h/%b", n, AddrB,
                         DataB, BusyB, exp_data(int'(AddrB)), exp_busy(int'(AddrB)));
            end
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_scoreboard();
        test_collision();
        test_bypass();
        test_out_of_range();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
